// File: rtl/div_share_arbiter_if.sv
// Bundle joining the two requesters, the divider sequencer and the shared divider.
// slave: sequencer view; master: requesters plus divider (bench side).
interface div_share_arbiter_if #(
  parameter int unsigned DW = 24,
  parameter int unsigned VW = 8,
  parameter int unsigned QW = 16
);
  logic          a_req;
  logic [DW-1:0] a_dividend;
  logic [VW-1:0] a_divisor;
  logic          a_ack;
  logic          b_req;
  logic [DW-1:0] b_dividend;
  logic [VW-1:0] b_divisor;
  logic          b_ack;
  logic [QW-1:0] result;
  logic          err;
  logic          busy;
  logic [DW-1:0] div_dividend;
  logic [VW-1:0] div_divisor;
  logic          div_start;
  logic [QW-1:0] div_quotient;
  logic          div_done;

  modport slave (
    input  a_req, a_dividend, a_divisor, b_req, b_dividend, b_divisor,
           div_quotient, div_done,
    output a_ack, b_ack, result, err, busy, div_dividend, div_divisor, div_start
  );

  modport master (
    output a_req, a_dividend, a_divisor, b_req, b_dividend, b_divisor,
           div_quotient, div_done,
    input  a_ack, b_ack, result, err, busy, div_dividend, div_divisor, div_start
  );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one restoring divider between requesters A and B.
// Optional WAIT watchdog enabled by defining DIV_ARB_TIMEOUT_EN.
module div_share_arbiter #(
  parameter int unsigned DW          = 24,
  parameter int unsigned VW          = 8,
  parameter int unsigned QW          = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic                clk,
  input logic                reset,
  div_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam int unsigned   HW    = DW - QW;
  localparam int unsigned   CW    = HW + VW;
  localparam logic [QW-1:0] ERR_Q = '1;

  state_t        state, state_nx;
  logic          last_grant, last_grant_nx;   // 0: A, 1: B
  logic          owner, owner_nx;
  logic [DW-1:0] dd_q, dd_nx;
  logic [VW-1:0] dv_q, dv_nx;
  logic [QW-1:0] result_q, result_nx;
  logic          err_q, err_nx;
  logic          a_ack_q, a_ack_nx;
  logic          b_ack_q, b_ack_nx;
  logic          start_q, start_nx;
  logic          busy_q, busy_nx;
  logic          pick_b;
  logic [DW-1:0] dd_sel;
  logic [VW-1:0] dv_sel;
  logic          timeout;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Watchdog: cleared in LAUNCH, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset || state == LAUNCH) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign timeout = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next state, arbitration and registered-output next values.
  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    owner_nx      = owner;
    dd_nx         = dd_q;
    dv_nx         = dv_q;
    result_nx     = result_q;
    err_nx        = err_q;
    pick_b        = 1'b0;
    dd_sel        = bus.a_dividend;
    dv_sel        = bus.a_divisor;

    case (state)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          pick_b        = bus.b_req && (!bus.a_req || !last_grant);
          owner_nx      = pick_b;
          last_grant_nx = pick_b;
          dd_sel        = pick_b ? bus.b_dividend : bus.a_dividend;
          dv_sel        = pick_b ? bus.b_divisor  : bus.a_divisor;
          dd_nx         = dd_sel;
          dv_nx         = dv_sel;
          // Zero divisor or a quotient wider than QW never reaches the divider.
          if (dv_sel == '0 || CW'(dd_sel[DW-1:QW]) >= CW'(dv_sel)) begin
            state_nx  = RESP;
            result_nx = ERR_Q;
            err_nx    = 1'b1;
          end else begin
            state_nx  = LAUNCH;
          end
        end
      end
      LAUNCH: state_nx = WAIT;
      WAIT: begin
        if (bus.div_done) begin
          state_nx  = RESP;
          result_nx = bus.div_quotient;
          err_nx    = 1'b0;
        end else if (timeout) begin
          state_nx  = RESP;
          result_nx = ERR_Q;
          err_nx    = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    a_ack_nx = (state_nx == RESP) && !owner_nx;
    b_ack_nx = (state_nx == RESP) &&  owner_nx;
    start_nx = (state_nx == LAUNCH);
    busy_nx  = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      dd_q       <= '0;
      dv_q       <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      owner      <= owner_nx;
      dd_q       <= dd_nx;
      dv_q       <= dv_nx;
      result_q   <= result_nx;
      err_q      <= err_nx;
      a_ack_q    <= a_ack_nx;
      b_ack_q    <= b_ack_nx;
      start_q    <= start_nx;
      busy_q     <= busy_nx;
    end
  end

  assign bus.a_ack        = a_ack_q;
  assign bus.b_ack        = b_ack_q;
  assign bus.result       = result_q;
  assign bus.err          = err_q;
  assign bus.busy         = busy_q;
  assign bus.div_dividend = dd_q;
  assign bus.div_divisor  = dv_q;
  assign bus.div_start    = start_q;
endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural latency-programmable divider.
module tb_div_share_arbiter;
  localparam int unsigned DW = 24, VW = 8, QW = 16, TMO = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  div_share_arbiter_if #(.DW(DW), .VW(VW), .QW(QW)) bus ();

  div_share_arbiter #(.DW(DW), .VW(VW), .QW(QW), .TIMEOUT_CYC(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Divider model: done pulses div_lat+1 edges after it sees start; stub never finishes.
  logic    stub;
  int      div_lat;
  int      dcnt;
  logic [QW-1:0] dq;

  always @(posedge clk) begin
    if (reset) begin
      dcnt             <= 0;
      dq               <= '0;
      bus.div_done     <= 1'b0;
      bus.div_quotient <= '0;
    end else begin
      bus.div_done <= 1'b0;
      if (bus.div_start) begin
        dcnt <= stub ? 0 : div_lat;
        dq   <= (bus.div_divisor == '0) ? 16'hFFFF
                : 16'(bus.div_dividend / 24'(bus.div_divisor));
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) begin
          bus.div_done     <= 1'b1;
          bus.div_quotient <= dq;
        end
      end
    end
  end

  typedef struct {
    logic          use_b;
    logic [DW-1:0] dd;
    logic [VW-1:0] dv;
    logic [QW-1:0] exp_res;
    logic          exp_err;
    int            exp_starts;
  } vec_t;

  vec_t vecs[8];

  int            w_who, w_starts, w_busy_at, w_start_at, w_ack_at, w_both;
  logic [QW-1:0] w_res;
  logic          w_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Step cycles until an ack appears or the budget runs out (w_who = -1).
  task automatic wait_ack(input int budget);
    w_who = -1; w_starts = 0; w_busy_at = -1; w_start_at = -1; w_ack_at = -1; w_both = 0;
    w_res = '0; w_err = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (bus.busy && w_busy_at < 0) w_busy_at = c;
      if (bus.div_start) begin
        w_starts++;
        if (w_start_at < 0) w_start_at = c;
      end
      if (bus.a_ack && bus.b_ack) w_both = 1;
      if (bus.a_ack || bus.b_ack) begin
        w_who    = bus.a_ack ? 0 : 1;
        w_res    = bus.result;
        w_err    = bus.err;
        w_ack_at = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 24'h2BA891, 8'h3A, 16'hC0B3, 1'b0, 1};
    vecs[1] = '{1'b1, 24'h000000, 8'h00, 16'hFFFF, 1'b1, 0};
    vecs[2] = '{1'b0, 24'hFFFFFF, 8'h01, 16'hFFFF, 1'b1, 0};
    vecs[3] = '{1'b1, 24'h000100, 8'h10, 16'h0010, 1'b0, 1};
    vecs[4] = '{1'b0, 24'h00FFFF, 8'h01, 16'hFFFF, 1'b0, 1};
    vecs[5] = '{1'b1, 24'h010000, 8'h01, 16'hFFFF, 1'b1, 0};
    vecs[6] = '{1'b0, 24'h7FFFFF, 8'h80, 16'hFFFF, 1'b0, 1};
    vecs[7] = '{1'b1, 24'h000005, 8'hFF, 16'h0000, 1'b0, 1};

    stub = 1'b0; div_lat = 3;
    bus.a_req = 1'b0; bus.a_dividend = '0; bus.a_divisor = '0;
    bus.b_req = 1'b0; bus.b_dividend = '0; bus.b_divisor = '0;
    do_reset();
    chk("reset_outputs", 32'({bus.a_ack, bus.b_ack, bus.err, bus.busy, bus.div_start}), 32'd0);
    chk("reset_result", 32'(bus.result), 32'd0);
    chk("reset_operands", 32'({bus.div_dividend, bus.div_divisor}), 32'd0);
    reset = 1'b0;

    // Single-requester table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].use_b) begin
        bus.b_req = 1'b1; bus.b_dividend = vecs[i].dd; bus.b_divisor = vecs[i].dv;
      end else begin
        bus.a_req = 1'b1; bus.a_dividend = vecs[i].dd; bus.a_divisor = vecs[i].dv;
      end
      wait_ack(50);
      bus.a_req = 1'b0; bus.b_req = 1'b0;
      chk($sformatf("v%0d_who", i), 32'(w_who), 32'(vecs[i].use_b));
      chk($sformatf("v%0d_result", i), 32'(w_res), 32'(vecs[i].exp_res));
      chk($sformatf("v%0d_err", i), 32'(w_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_starts", i), 32'(w_starts), 32'(vecs[i].exp_starts));
      if (vecs[i].exp_starts == 0)
        chk($sformatf("v%0d_err_latency", i), 32'(w_ack_at), 32'(w_busy_at));
      else begin
        chk($sformatf("v%0d_start_at_grant", i), 32'(w_start_at), 32'(w_busy_at));
        chk($sformatf("v%0d_ack_latency", i), 32'(w_ack_at - w_start_at), 32'(div_lat + 2));
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_after", i), 32'({bus.busy, bus.a_ack, bus.b_ack}), 32'd0);
      chk($sformatf("v%0d_result_held", i), 32'(bus.result), 32'(vecs[i].exp_res));
    end

    // Both requesters rise together out of reset: A first, then B
    do_reset();
    bus.a_req = 1'b1; bus.a_dividend = 24'h2BA891; bus.a_divisor = 8'h3A;
    bus.b_req = 1'b1; bus.b_dividend = 24'h000100; bus.b_divisor = 8'h10;
    reset = 1'b0;
    wait_ack(50);
    bus.a_req = 1'b0;
    chk("tie_first_who", 32'(w_who), 32'd0);
    chk("tie_first_result", 32'(w_res), 32'h0000C0B3);
    chk("tie_first_starts", 32'(w_starts), 32'd1);
    wait_ack(50);
    chk("tie_second_who", 32'(w_who), 32'd1);
    chk("tie_second_result", 32'(w_res), 32'h00000010);
    chk("tie_second_starts", 32'(w_starts), 32'd1);
    chk("tie_one_ack", 32'(w_both), 32'd0);

    // Both held for six operations: strict alternation starting with A
    bus.a_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_ack(50);
      chk($sformatf("rr%0d_who", k), 32'(w_who), 32'(k % 2));
      chk($sformatf("rr%0d_one_ack", k), 32'(w_both), 32'd0);
      chk($sformatf("rr%0d_result", k), 32'(w_res), (k % 2 == 0) ? 32'h0000C0B3 : 32'h00000010);
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(posedge clk); #1;

    // Reset while in WAIT discards the operation
    div_lat = 20;
    bus.a_req = 1'b1;
    wait_ack(2);
    chk("rst_wait_started", 32'(w_starts), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    div_lat = 3;
    @(posedge clk); #1;
    chk("rst_wait_busy", 32'(bus.busy), 32'd0);
    chk("rst_wait_no_ack", 32'({bus.a_ack, bus.b_ack}), 32'd0);
    chk("rst_wait_cleared", 32'({bus.result, bus.err, bus.div_start}), 32'd0);
    reset = 1'b0;
    wait_ack(50);
    bus.a_req = 1'b0;
    chk("rst_after_who", 32'(w_who), 32'd0);
    chk("rst_after_result", 32'(w_res), 32'h0000C0B3);
    chk("rst_after_err", 32'(w_err), 32'd0);
    @(posedge clk); #1;

    // Divider that never completes
    stub = 1'b1;
    bus.a_req = 1'b1;
`ifdef DIV_ARB_TIMEOUT_EN
    wait_ack(200);
    bus.a_req = 1'b0;
    chk("tmo_who", 32'(w_who), 32'd0);
    chk("tmo_result", 32'(w_res), 32'h0000FFFF);
    chk("tmo_err", 32'(w_err), 32'd1);
    chk("tmo_latency", 32'(w_ack_at - w_start_at), 32'(TMO + 1));
`else
    wait_ack(150);
    chk("hang_no_ack", 32'(w_who), 32'hFFFFFFFF);
    chk("hang_busy", 32'(bus.busy), 32'd1);
    chk("hang_started", 32'(w_starts), 32'd1);
    bus.a_req = 1'b0;
`endif
    stub = 1'b0;
    do_reset();
    reset = 1'b0;
    chk("final_idle", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
